apb_slave_regbank: RTL and testbench

- APB responder at the far end of the bridge: one peripheral slot, selected by one bit of the bridge's 3-bit psel.
- Holds a bank of 32-bit read/write registers plus one read-only counter of completed writes.
- Inserts a programmable number of wait states through pready and flags bad accesses through pslverr.
- Serves as the bus-functional APB endpoint for bridge integration benches and as the template for real peripherals.

---
 rtl/apb_slave_regbank_if.sv | 22 ++
 rtl/apb_slave_regbank.sv | 107 ++++++++++
 tb/tb_apb_slave_regbank.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_regbank_if.sv
// APB completer-side bus bundle for one peripheral slot of the bridge.
// The master modport drives the request; the slave modport answers it.
interface apb_slave_regbank_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_regbank.sv
// APB register bank: NUM_REGS-1 read/write words plus a read-only count of
// completed writes in the top slot, with programmable wait states.
module apb_slave_regbank #(
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 0,
    parameter int OFFSET_BITS = 12
) (
    input  logic               hclk,
    input  logic               hresetn,
    apb_slave_regbank_if.slave bus
);

    localparam int              IDX_W   = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0] CNT_IDX = IDX_W'(NUM_REGS - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             wait_q, wait_d;
    logic [OFFSET_BITS-1:0] addr_q;
    logic                   write_q;
    logic [31:0]            wdata_q;
    logic [31:0]            regs_q [NUM_REGS-1];
    logic [31:0]            wr_cnt_q;

    logic                   latch;
    logic                   complete;
    logic                   ready;
    logic                   err;
    logic [IDX_W-1:0]       idx;
    logic [31:0]            rd_val;
    logic                   unused_paddr_hi;

    assign unused_paddr_hi = ^bus.paddr[31:OFFSET_BITS];

    // Decode works only on the setup-phase latch, never on the live bus.
    assign idx = addr_q[IDX_W+1:2];
    assign err = (addr_q[1:0] != 2'b00)
              || ((addr_q >> (IDX_W + 2)) != '0)
              || (write_q && (idx == CNT_IDX));
    assign rd_val = (idx == CNT_IDX) ? wr_cnt_q : regs_q[idx];

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        latch    = 1'b0;
        complete = 1'b0;
        ready    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.psel && !bus.penable) begin
                    latch   = 1'b1;
                    wait_d  = 4'(WAIT_STATES);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                ready = (wait_q == 4'd0);
                if (!bus.psel) begin
                    state_d = IDLE;
                end else if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.pready  = ready;
    assign bus.pslverr = ready && err;
    assign bus.prdata  = (ready && !err && !write_q) ? rd_val : 32'd0;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_ff @(posedge hclk) begin
        if (latch) begin
            addr_q  <= bus.paddr[OFFSET_BITS-1:0];
            write_q <= bus.pwrite;
            wdata_q <= bus.pwdata;
        end
    end

    // A good write updates its register and bumps the counter on the same edge.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                regs_q[i] <= 32'd0;
            end
            wr_cnt_q <= 32'd0;
        end else if (complete && write_q && !err) begin
            regs_q[idx] <= wdata_q;
            wr_cnt_q    <= wr_cnt_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench for apb_slave_regbank: three instances with 0, 2 and 3 wait
// states share one APB master; sel chooses which slot the master talks to.
module tb_apb_slave_regbank;

    logic        hclk;
    logic        hresetn;
    logic [1:0]  sel;
    logic        m_psel, m_penable, m_pwrite;
    logic [31:0] m_paddr, m_pwdata;
    logic        s_ready, s_slverr;
    logic [31:0] s_prdata;
    int          n_chk;
    int          n_fail;

    apb_slave_regbank_if ifc0 ();
    apb_slave_regbank_if ifc2 ();
    apb_slave_regbank_if ifc3 ();

    apb_slave_regbank #(.NUM_REGS(8), .WAIT_STATES(0), .OFFSET_BITS(12)) u0 (
        .hclk(hclk), .hresetn(hresetn), .bus(ifc0.slave));
    apb_slave_regbank #(.NUM_REGS(8), .WAIT_STATES(2), .OFFSET_BITS(12)) u2 (
        .hclk(hclk), .hresetn(hresetn), .bus(ifc2.slave));
    apb_slave_regbank #(.NUM_REGS(8), .WAIT_STATES(3), .OFFSET_BITS(12)) u3 (
        .hclk(hclk), .hresetn(hresetn), .bus(ifc3.slave));

    assign ifc0.psel = m_psel && (sel == 2'd0);
    assign ifc2.psel = m_psel && (sel == 2'd1);
    assign ifc3.psel = m_psel && (sel == 2'd2);
    assign ifc0.penable = m_penable;
    assign ifc2.penable = m_penable;
    assign ifc3.penable = m_penable;
    assign ifc0.pwrite = m_pwrite;
    assign ifc2.pwrite = m_pwrite;
    assign ifc3.pwrite = m_pwrite;
    assign ifc0.paddr = m_paddr;
    assign ifc2.paddr = m_paddr;
    assign ifc3.paddr = m_paddr;
    assign ifc0.pwdata = m_pwdata;
    assign ifc2.pwdata = m_pwdata;
    assign ifc3.pwdata = m_pwdata;

    assign s_ready  = (sel == 2'd0) ? ifc0.pready  : (sel == 2'd1) ? ifc2.pready  : ifc3.pready;
    assign s_slverr = (sel == 2'd0) ? ifc0.pslverr : (sel == 2'd1) ? ifc2.pslverr : ifc3.pslverr;
    assign s_prdata = (sel == 2'd0) ? ifc0.prdata  : (sel == 2'd1) ? ifc2.prdata  : ifc3.prdata;

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Full transfer starting #1 after an edge; ends #1 after the completing edge
    // with psel still high so another call issues its setup back-to-back.
    task automatic xfer(input logic [1:0] s, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int waits);
        bit done;
        done  = 1'b0;
        waits = 0;
        rdata = '0;
        err   = 1'b0;
        sel = s; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = wr;
        m_paddr = addr; m_pwdata = wdata;
        @(posedge hclk); #1;
        m_penable = 1'b1;
        m_paddr   = ~addr;
        m_pwdata  = ~wdata;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge hclk);
            if (s_ready) begin
                rdata = s_prdata;
                err   = s_slverr;
                done  = 1'b1;
            end else begin
                waits++;
            end
            @(posedge hclk); #1;
        end
        if (!done) chk("xfer_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        m_psel = 1'b0; m_penable = 1'b0;
        @(posedge hclk); #1;
    endtask

    task automatic wr(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                      input logic exp_err, input string tag);
        logic [31:0] rd_d; logic e; int w;
        xfer(s, 1'b1, a, d, rd_d, e, w);
        chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
        chk({tag, "_rdata"}, rd_d, 32'd0);
        idle();
    endtask

    task automatic rd(input logic [1:0] s, input logic [31:0] a, input logic [31:0] exp,
                      input logic exp_err, input string tag);
        logic [31:0] rd_d; logic e; int w;
        xfer(s, 1'b0, a, 32'd0, rd_d, e, w);
        chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
        chk({tag, "_data"}, rd_d, exp);
        idle();
    endtask

    initial begin
        logic [31:0] r; logic e; int w;
        n_chk = 0; n_fail = 0;
        hresetn = 1'b0; sel = 2'd0;
        m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0;
        m_paddr = '0; m_pwdata = '0;
        repeat (3) @(posedge hclk);
        #1;
        chk("rst_pready", {31'd0, s_ready}, 32'd0);
        chk("rst_prdata", s_prdata, 32'd0);
        chk("rst_pslverr", {31'd0, s_slverr}, 32'd0);
        hresetn = 1'b1;
        @(posedge hclk); #1;

        // zero-wait slot: basic write/read and counter
        xfer(2'd0, 1'b1, 32'h4, 32'hDEAD_BEEF, r, e, w);
        chk("w4_waits", 32'(w), 32'd0);
        chk("w4_err", {31'd0, e}, 32'd0);
        idle();
        rd(2'd0, 32'h4, 32'hDEAD_BEEF, 1'b0, "r4");
        rd(2'd0, 32'h1C, 32'd1, 1'b0, "rcnt1");
        rd(2'd0, 32'h1000_0004, 32'hDEAD_BEEF, 1'b0, "r4_hi");
        wr(2'd0, 32'h0, 32'h11, 1'b0, "w0");

        // error responses
        wr(2'd0, 32'h2, 32'hFFFF, 1'b1, "w2_unal");
        rd(2'd0, 32'h0, 32'h11, 1'b0, "r0_keep");
        rd(2'd0, 32'h20, 32'd0, 1'b1, "r20_oor");
        wr(2'd0, 32'h1C, 32'h5, 1'b1, "wcnt_ro");
        rd(2'd0, 32'h1C, 32'd2, 1'b0, "rcnt2");

        // counter wrap
        force u0.wr_cnt_q = 32'hFFFF_FFFF;
        #1;
        release u0.wr_cnt_q;
        rd(2'd0, 32'h1C, 32'hFFFF_FFFF, 1'b0, "rcnt_pre");
        wr(2'd0, 32'h8, 32'h1, 1'b0, "w8_wrap");
        rd(2'd0, 32'h1C, 32'd0, 1'b0, "rcnt_wrap");

        // three wait states
        xfer(2'd2, 1'b0, 32'h0, 32'd0, r, e, w);
        chk("ws3_waits", 32'(w), 32'd3);
        chk("ws3_data", r, 32'd0);
        chk("ws3_err", {31'd0, e}, 32'd0);
        idle();

        // abort in the second access cycle of a two-wait write
        sel = 2'd1; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1;
        m_paddr = 32'h8; m_pwdata = 32'hCAFE_0001;
        @(posedge hclk); #1;
        m_penable = 1'b1;
        @(posedge hclk); #1;
        m_psel = 1'b0; m_penable = 1'b0;
        @(negedge hclk);
        chk("abort_pready", {31'd0, s_ready}, 32'd0);
        @(posedge hclk); #1;
        rd(2'd1, 32'h8, 32'd0, 1'b0, "abort_r8");
        rd(2'd1, 32'h1C, 32'd0, 1'b0, "abort_cnt");
        wr(2'd1, 32'h8, 32'h1234, 1'b0, "w8_after");
        rd(2'd1, 32'h8, 32'h1234, 1'b0, "r8_after");
        wr(2'd1, 32'hC, 32'hAAAA, 1'b0, "wC");

        // reset while the completing access cycle is on the bus
        sel = 2'd1; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b0;
        m_paddr = 32'hC; m_pwdata = 32'd0;
        @(posedge hclk); #1;
        m_penable = 1'b1;
        repeat (2) @(posedge hclk);
        #2;
        chk("prerst_pready", {31'd0, s_ready}, 32'd1);
        chk("prerst_prdata", s_prdata, 32'hAAAA);
        hresetn = 1'b0;
        #1;
        chk("midrst_pready", {31'd0, s_ready}, 32'd0);
        chk("midrst_prdata", s_prdata, 32'd0);
        m_psel = 1'b0; m_penable = 1'b0;
        @(posedge hclk); #1;
        hresetn = 1'b1;
        @(posedge hclk); #1;
        rd(2'd1, 32'hC, 32'd0, 1'b0, "postrst_rC");
        rd(2'd1, 32'h8, 32'd0, 1'b0, "postrst_r8");
        rd(2'd1, 32'h1C, 32'd0, 1'b0, "postrst_cnt");
        rd(2'd0, 32'h4, 32'd0, 1'b0, "postrst_u0r4");

        // back-to-back writes on the zero-wait slot
        xfer(2'd0, 1'b1, 32'h0, 32'h1111_0000, r, e, w);
        chk("b2b0_err", {31'd0, e}, 32'd0);
        xfer(2'd0, 1'b1, 32'h4, 32'h2222_0004, r, e, w);
        chk("b2b1_err", {31'd0, e}, 32'd0);
        xfer(2'd0, 1'b1, 32'h8, 32'h3333_0008, r, e, w);
        chk("b2b2_err", {31'd0, e}, 32'd0);
        idle();
        rd(2'd0, 32'h0, 32'h1111_0000, 1'b0, "b2b_r0");
        rd(2'd0, 32'h4, 32'h2222_0004, 1'b0, "b2b_r4");
        rd(2'd0, 32'h8, 32'h3333_0008, 1'b0, "b2b_r8");
        rd(2'd0, 32'h1C, 32'd3, 1'b0, "b2b_cnt");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
